walu_pipe: RTL

//  Parametrised, pipelined successor of the single-cycle word ALU. Accepts one

---
 rtl/walu_pipe.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/walu_pipe.sv
// Pipelined word ALU: valid/ready in, LATENCY register stages, registered
// result/flags/tag out. Stages collapse bubbles and stall under back-pressure.
module walu_pipe #(
    parameter int WIDTH   = 32,
    parameter int LATENCY = 2,
    parameter int TAG_W   = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [3:0]       in_op,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_r,
    output logic             out_c,
    output logic             out_v,
    output logic             out_z,
    output logic             out_err,
    output logic [TAG_W-1:0] out_tag
);

    localparam int SH = $clog2(WIDTH);

    typedef enum logic [3:0] {
        OP_ADD = 4'd0,
        OP_SUB = 4'd1,
        OP_AND = 4'd2,
        OP_OR  = 4'd3,
        OP_XOR = 4'd4,
        OP_SLL = 4'd5,
        OP_SRL = 4'd6,
        OP_SRA = 4'd7,
        OP_MUL = 4'd8,
        OP_SLT = 4'd9
    } op_e;

    logic [WIDTH:0]   sum_add;
    logic [WIDTH:0]   sum_sub;
    logic [WIDTH-1:0] prod;
    logic [WIDTH-1:0] sra_r;
    logic [SH-1:0]    amt;
    logic             slt;
    logic             v_add;
    logic             v_sub;

    logic [WIDTH-1:0] alu_r;
    logic             alu_c;
    logic             alu_v;
    logic             alu_z;
    logic             alu_err;

    assign amt     = in_b[SH-1:0];
    assign sum_add = {1'b0, in_a} + {1'b0, in_b};
    assign sum_sub = {1'b0, in_a} + {1'b0, ~in_b} + {{WIDTH{1'b0}}, 1'b1};
    assign prod    = in_a * in_b;
    assign sra_r   = $unsigned($signed(in_a) >>> amt);
    assign slt     = $signed(in_a) < $signed(in_b);

    // Overflow: operands (b inverted for SUB) agree in sign but result differs.
    assign v_add = (in_a[WIDTH-1] == in_b[WIDTH-1]) & (sum_add[WIDTH-1] ^ in_a[WIDTH-1]);
    assign v_sub = (in_a[WIDTH-1] != in_b[WIDTH-1]) & (sum_sub[WIDTH-1] ^ in_a[WIDTH-1]);

    always_comb begin
        alu_r   = '0;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        alu_err = 1'b0;
        case (op_e'(in_op))
            OP_ADD: begin
                alu_r = sum_add[WIDTH-1:0];
                alu_c = sum_add[WIDTH];
                alu_v = v_add;
            end
            OP_SUB: begin
                alu_r = sum_sub[WIDTH-1:0];
                alu_c = sum_sub[WIDTH];
                alu_v = v_sub;
            end
            OP_AND:  alu_r = in_a & in_b;
            OP_OR:   alu_r = in_a | in_b;
            OP_XOR:  alu_r = in_a ^ in_b;
            OP_SLL:  alu_r = in_a << amt;
            OP_SRL:  alu_r = in_a >> amt;
            OP_SRA:  alu_r = sra_r;
            OP_MUL:  alu_r = prod;
            OP_SLT:  alu_r = {{(WIDTH-1){1'b0}}, slt};
            default: alu_err = 1'b1;
        endcase
    end

    assign alu_z = (alu_r == '0);

    logic [LATENCY-1:0] vld;
    logic [LATENCY-1:0] en;
    logic [LATENCY-1:0] vld_d;
    logic [LATENCY-1:0] c_q;
    logic [LATENCY-1:0] c_d;
    logic [LATENCY-1:0] v_q;
    logic [LATENCY-1:0] v_d;
    logic [LATENCY-1:0] z_q;
    logic [LATENCY-1:0] z_d;
    logic [LATENCY-1:0] err_q;
    logic [LATENCY-1:0] err_d;
    logic [WIDTH-1:0]   r_q   [LATENCY];
    logic [WIDTH-1:0]   r_d   [LATENCY];
    logic [TAG_W-1:0]   tag_q [LATENCY];
    logic [TAG_W-1:0]   tag_d [LATENCY];

    for (genvar k = 0; k < LATENCY; k++) begin : g_stage
        // A stage may load when it or any stage downstream of it has a hole,
        // or when the consumer takes the head this cycle.
        assign en[k] = out_ready | ~(&vld[LATENCY-1:k]);

        if (k == 0) begin : g_src_alu
            assign vld_d[k] = in_valid;
            assign r_d[k]   = alu_r;
            assign c_d[k]   = alu_c;
            assign v_d[k]   = alu_v;
            assign z_d[k]   = alu_z;
            assign err_d[k] = alu_err;
            assign tag_d[k] = in_tag;
        end else begin : g_src_prev
            assign vld_d[k] = vld[k-1];
            assign r_d[k]   = r_q[k-1];
            assign c_d[k]   = c_q[k-1];
            assign v_d[k]   = v_q[k-1];
            assign z_d[k]   = z_q[k-1];
            assign err_d[k] = err_q[k-1];
            assign tag_d[k] = tag_q[k-1];
        end

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                vld[k]   <= 1'b0;
                r_q[k]   <= '0;
                c_q[k]   <= 1'b0;
                v_q[k]   <= 1'b0;
                z_q[k]   <= 1'b0;
                err_q[k] <= 1'b0;
                tag_q[k] <= '0;
            end else if (en[k]) begin
                vld[k]   <= vld_d[k];
                r_q[k]   <= r_d[k];
                c_q[k]   <= c_d[k];
                v_q[k]   <= v_d[k];
                z_q[k]   <= z_d[k];
                err_q[k] <= err_d[k];
                tag_q[k] <= tag_d[k];
            end
        end
    end

    assign in_ready  = en[0];
    assign out_valid = vld[LATENCY-1];
    assign out_r     = r_q[LATENCY-1];
    assign out_c     = c_q[LATENCY-1];
    assign out_v     = v_q[LATENCY-1];
    assign out_z     = z_q[LATENCY-1];
    assign out_err   = err_q[LATENCY-1];
    assign out_tag   = tag_q[LATENCY-1];

endmodule
